// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory subsystem.
// Holds the arbiter state encoding, the datapath width constants used by the
// CPU top, and a helper that sizes the arbiter watchdog counter.
package cpu_mem_pkg;

    localparam int unsigned CPU_ADDR_W = 32;
    localparam int unsigned CPU_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } arb_state_t;

    // Counter width able to hold 0..timeout; a disabled watchdog still gets one bit.
    function automatic int unsigned wdog_cnt_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Watchdog for the memory arbiter.
// Counts cycles in which the granted memory transaction is still unanswered.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        restart the count (asserted on the grant edge)
//   enable_i       this cycle is an unanswered access cycle
//   expired_o      this is the TIMEOUT-th unanswered cycle; abort at the next edge
// TIMEOUT = 0 disables the watchdog (expired_o is never asserted).
module arb_watchdog
    import cpu_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = wdog_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_CNT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q unanswered cycles already elapsed; this one makes TIMEOUT.
    assign expired_o = (TIMEOUT != 0) && enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// instruction-fetch stage (read-only) and the MEM stage (read/write).
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   if_req_i/if_addr_i/if_flush_i     fetch request, address, branch flush
//   if_rdata_o/if_valid_o/if_stall_o  fetched word, completion, PC/IF-ID freeze
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request
//   dm_rdata_o/dm_valid_o/dm_stall_o  load data, completion, pipeline freeze
//   mem_*_o / mem_rdata_i/mem_ready_i memory port
//   err_o                             sticky watchdog error
// The data port wins in IDLE; each access returns to IDLE, so at most one
// access per two cycles and a waiting fetch is granted right after a data access.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned DATA_W  = CPU_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              err_o
);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;

    logic grant_dm, grant_if, in_acc, done, timeout, drop;

    assign grant_dm = (state_q == IDLE) && dm_req_i;
    assign grant_if = (state_q == IDLE) && !dm_req_i && if_req_i && !if_flush_i;
    assign in_acc   = (state_q != IDLE);
    assign done     = in_acc && mem_ready_i && mem_req_q;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (grant_dm || grant_if),
        .enable_i  (in_acc && !mem_ready_i),
        .expired_o (timeout)
    );

    // A flush arriving in the completion cycle also discards the fetched word.
    assign drop = drop_q || if_flush_i;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d     = DM_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end else if (grant_if) begin
                    state_d    = IF_ACC;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                end
            end
            IF_ACC, DM_ACC: begin
                // done is checked first so a ready in the expiry cycle completes.
                if (done) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (timeout) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // drop lives only while the fetch is outstanding.
    assign drop_d = (state_q == IF_ACC) && !done && !timeout && drop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;

    assign if_rdata_o = mem_rdata_i;
    assign dm_rdata_o = mem_rdata_i;
    assign dm_valid_o = (state_q == DM_ACC) && mem_ready_i;
    assign if_valid_o = (state_q == IF_ACC) && mem_ready_i && !drop;
    assign if_stall_o = if_req_i && !if_valid_o;
    assign dm_stall_o = dm_req_i && !dm_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT = 4).
// Inputs change 1ns after the rising edge; outputs are checked 2ns after the
// edge by the sequence and at the falling edge by the completion monitor, which
// pops the expected transaction queued when the request was driven.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, dm_req, dm_we, mem_ready;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, err;

    typedef struct {
        logic          is_dm;
        logic          chk_data;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_flush_i  (if_flush),
        .if_rdata_o  (if_rdata),
        .if_valid_o  (if_valid),
        .if_stall_o  (if_stall),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .dm_valid_o  (dm_valid),
        .dm_stall_o  (dm_stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready),
        .err_o       (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_dm, input logic chk_data, input logic [DW-1:0] data,
                        input logic [AW-1:0] addr);
        exp_t e;
        e.is_dm    = is_dm;
        e.chk_data = chk_data;
        e.data     = data;
        e.addr     = addr;
        sb.push_back(e);
    endtask

    // Completion monitor: every valid must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (if_valid || dm_valid)) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'({if_valid, dm_valid}), 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_port", 64'({if_valid, dm_valid}), e.is_dm ? 64'd1 : 64'd2);
                check("sb_addr", 64'(mem_addr), 64'(e.addr));
                if (e.chk_data) begin
                    check("sb_rdata", 64'(e.is_dm ? dm_rdata : if_rdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        {if_req, if_flush, dm_req, dm_we, mem_ready} = '0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_stalls", 64'({if_stall, dm_stall}), 64'd0);
        check("rst_valids", 64'({if_valid, dm_valid}), 64'd0);
        step();

        // IF only: request in cycle 1, ready in cycle 4.
        if_req = 1'b1; if_addr = 32'h10;
        push(1'b0, 1'b1, 32'h8C02_0004, 32'h10);
        #1;
        check("if1_stall_c1", 64'(if_stall), 64'd1);
        check("if1_req_c1", 64'(mem_req), 64'd0);
        step();
        for (int c = 2; c <= 3; c++) begin
            #1;
            check("if1_mem_req", 64'(mem_req), 64'd1);
            check("if1_mem_addr", 64'(mem_addr), 64'h10);
            check("if1_mem_we", 64'(mem_we), 64'd0);
            check("if1_stall", 64'(if_stall), 64'd1);
            step();
        end
        mem_ready = 1'b1; mem_rdata = 32'h8C02_0004;
        #1;
        check("if1_valid", 64'(if_valid), 64'd1);
        check("if1_rdata", 64'(if_rdata), 64'h8C02_0004);
        check("if1_stall_c4", 64'(if_stall), 64'd0);
        step();
        if_req = 1'b0; mem_ready = 1'b0;
        #1;
        check("if1_idle_req", 64'(mem_req), 64'd0);
        step();

        // Contention: DM write wins, fetch follows on the next IDLE.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h80;
        push(1'b1, 1'b0, '0, 32'h40);
        push(1'b0, 1'b1, 32'h0000_1234, 32'h80);
        #1;
        check("ct_stalls", 64'({if_stall, dm_stall}), 64'd3);
        step();
        #1;
        check("ct_dm_addr", 64'(mem_addr), 64'h40);
        check("ct_dm_we", 64'(mem_we), 64'd1);
        check("ct_dm_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        mem_ready = 1'b1;
        #1;
        check("ct_dm_valid", 64'(dm_valid), 64'd1);
        check("ct_stalls_done", 64'({if_stall, dm_stall}), 64'd2);
        step();
        dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
        #1;
        check("ct_idle_req", 64'(mem_req), 64'd0);
        step();
        #1;
        check("ct_if_req", 64'(mem_req), 64'd1);
        check("ct_if_addr", 64'(mem_addr), 64'h80);
        check("ct_if_we", 64'(mem_we), 64'd0);
        mem_ready = 1'b1; mem_rdata = 32'h0000_1234;
        step();
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        // Flush during IF_ACC: old fetch silently completes, then 0x20 is fetched.
        if_req = 1'b1; if_addr = 32'h10;
        step();
        #1;
        check("fl_old_addr", 64'(mem_addr), 64'h10);
        if_flush = 1'b1; if_addr = 32'h20;
        step();
        if_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        push(1'b0, 1'b1, 32'h5555_AAAA, 32'h20);
        #1;
        check("fl_dropped_valid", 64'(if_valid), 64'd0);
        check("fl_stall_drop", 64'(if_stall), 64'd1);
        step();
        mem_ready = 1'b0;
        #1;
        check("fl_idle_req", 64'(mem_req), 64'd0);
        check("fl_stall_idle", 64'(if_stall), 64'd1);
        step();
        #1;
        check("fl_new_addr", 64'(mem_addr), 64'h20);
        check("fl_stall_new", 64'(if_stall), 64'd1);
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        check("fl_new_valid", 64'(if_valid), 64'd1);
        step();
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        // Flush in IDLE blocks that cycle's grant.
        if_req = 1'b1; if_addr = 32'h30; if_flush = 1'b1;
        step();
        #1;
        check("fi_blocked", 64'(mem_req), 64'd0);
        if_flush = 1'b0;
        push(1'b0, 1'b1, 32'h3030_3030, 32'h30);
        step();
        #1;
        check("fi_granted", 64'(mem_req), 64'd1);
        mem_ready = 1'b1; mem_rdata = 32'h3030_3030;
        step();
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        // Watchdog: four unanswered cycles after the grant abort the access.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
        step();
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("wd_req_held", 64'(mem_req), 64'd1);
            check("wd_err_low", 64'(err), 64'd0);
            check("wd_no_valid", 64'(dm_valid), 64'd0);
            step();
        end
        dm_req = 1'b0;
        #1;
        check("wd_err_set", 64'(err), 64'd1);
        check("wd_req_drop", 64'(mem_req), 64'd0);
        step();
        #1;
        check("wd_err_sticky", 64'(err), 64'd1);
        step();

        // Async reset while in DM_ACC.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h48; dm_wdata = 32'h1234_5678;
        step();
        #1;
        check("ar_req_high", 64'(mem_req), 64'd1);
        check("ar_err_still", 64'(err), 64'd1);
        #1;
        rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
        #1;
        check("ar_req_async", 64'(mem_req), 64'd0);
        check("ar_we", 64'(mem_we), 64'd0);
        check("ar_addr", 64'(mem_addr), 64'd0);
        check("ar_wdata", 64'(mem_wdata), 64'd0);
        check("ar_err_clr", 64'(err), 64'd0);
        check("ar_stalls", 64'({if_stall, dm_stall}), 64'd0);
        step();
        rst = 1'b0;
        // One-cycle grant latency shows the FSM restarted from IDLE.
        if_req = 1'b1; if_addr = 32'h50;
        push(1'b0, 1'b1, 32'h5050_5050, 32'h50);
        step();
        #1;
        check("ar_idle_grant", 64'(mem_req), 64'd1);
        check("ar_idle_addr", 64'(mem_addr), 64'h50);
        mem_ready = 1'b1; mem_rdata = 32'h5050_5050;
        step();
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency unified memory between the pipelined CPU's instruction-fetch stage (read-only) and its MEM stage (read/write). Owns the memory port through a small FSM and holds each transaction's address and data stable until the memory signals ready. Returns read data straight to the requester and generates per-stage stall signals that freeze the PC/IF-ID path or the whole pipeline. Also aborts fetches on branch flush and detects hung memory with a watchdog.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for mem_ready_i before abort; 0 disables watchdog

Ports:
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request, level, held until if_valid_o
- if_addr_i  in  ADDR_W  fetch address
- if_flush_i  in  1  abort current/pending fetch (branch taken)
- if_rdata_o  out  DATA_W  fetched word, valid with if_valid_o
- if_valid_o  out  1  fetch completes this cycle
- if_stall_o  out  1  freeze PC and IF/ID
- dm_req_i, dm_we_i  in  1 each  data request, write enable
- dm_addr_i  in  ADDR_W; dm_wdata_i  in  DATA_W
- dm_rdata_o  out  DATA_W; dm_valid_o  out  1
- dm_stall_o  out  1  freeze whole pipeline
- mem_req_o, mem_we_o  out  1 each  memory request, write
- mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W
- mem_rdata_i  in  DATA_W; mem_ready_i  in  1  completes current transaction
- err_o  out  1  sticky watchdog error

## Operation
- States: IDLE, IF_ACC, DM_ACC.
- IDLE grant: dm_req_i has priority; otherwise if_req_i & ~if_flush_i. At the grant edge, register addr/wdata/we into mem_*_o, set mem_req_o=1, enter *_ACC.
- mem_we_o=0 for IF grants.
- *_ACC: mem_*_o held stable. Completion = mem_ready_i & mem_req_o.
- At the completion edge: clear mem_req_o, return to IDLE. No back-to-back grant from *_ACC.
- Valid outputs are combinational in the completion cycle: dm_valid_o = DM_ACC & mem_ready_i; if_valid_o = IF_ACC & mem_ready_i & ~drop.
- rdata outputs pass mem_rdata_i through. For writes, dm_valid_o acknowledges completion.
- Flush: if_flush_i in IF_ACC sets drop. The transaction still runs to completion but if_valid_o is suppressed. drop clears on leaving IF_ACC.
- if_flush_i in IDLE blocks that cycle's IF grant.
- Stalls: if_stall_o = if_req_i & ~if_valid_o; dm_stall_o = dm_req_i & ~dm_valid_o.
- Watchdog: counter clears on entry to *_ACC and increments each cycle with mem_ready_i=0. On reaching TIMEOUT: err_o=1 (sticky until reset), mem_req_o=0, return to IDLE with no valid.
- Counter width is $clog2(TIMEOUT+1).
- Simultaneous mem_ready_i and timeout in the same cycle: completion wins.

## Timing
- Reset values: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, drop=0, counter=0, err_o=0. Combinational outputs follow from these.
- Reset mid-transaction: mem_req_o drops asynchronously and the transaction is lost.
- Latency: request seen in IDLE at cycle N → mem_req_o high at N+1 → valid in the cycle mem_ready_i=1 (earliest N+1).
- Throughput: at most one access per 2 cycles.
- Requesters must hold req/addr/wdata/we stable until valid.

## Structure
- Shared package cpu_mem_pkg holds:
  - arb_state_t enum: IDLE=2'd0, IF_ACC=2'd1, DM_ACC=2'd2
  - width constants shared with the CPU top
- One sub-module, arb_watchdog: counter with clear, enable, TIMEOUT parameter, expired output.
- FSM, grant and stall logic live in mem_port_arbiter.

## Test plan
- Reset: assert rst_i mid-simulation → all registered outputs 0, err_o=0, no stalls with requests low.
- IF only:
  - Stimulus: if_req_i at cycle 1, if_addr_i=0x10; mem_ready_i at cycle 4 with mem_rdata_i=0x8C020004.
  - Required: mem_req_o=1 and mem_addr_o=0x10 from cycle 2; if_valid_o=1 and if_rdata_o=0x8C020004 at cycle 4; if_stall_o=1 on cycles 1–3.
- Contention:
  - Stimulus: both requests in IDLE; dm_we_i=1, dm_addr_i=0x40, dm_wdata_i=0xDEADBEEF.
  - Required: DM granted first with mem_we_o=1 and mem_wdata_o=0xDEADBEEF; IF granted on the first IDLE after dm_valid_o.
- Flush:
  - Stimulus: if_flush_i during IF_ACC for addr 0x10; new if_req_i to 0x20.
  - Required: old transaction completes with if_valid_o=0; next grant has mem_addr_o=0x20; if_stall_o held until 0x20 completes.
- Watchdog (TIMEOUT=4):
  - Stimulus: mem_ready_i held 0.
  - Required: err_o=1 four cycles after grant; mem_req_o=0; no valid; err_o persists until reset.
- Async reset in DM_ACC: mem_req_o falls before the next clock edge; state returns to IDLE.
